// File: rtl/svt_phase_sequencer_if.sv
// svt_phase_sequencer_if: test-control and requester bus of the phase sequencer
interface svt_phase_sequencer_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int TIMEOUT_W = 16
);
  logic start;
  logic [TIMEOUT_W-1:0] run_limit;
  logic [N_REQ-1:0] phase_ack, raise, drop;
  logic [2:0] phase;
  logic phase_start;
  logic [CNT_W+3:0] obj_total;
  logic done, timeout, err_underflow, err_overflow;
  modport master (
    output start, run_limit, phase_ack, raise, drop,
    input phase, phase_start, obj_total, done, timeout, err_underflow, err_overflow
  );
  modport slave (
    input start, run_limit, phase_ack, raise, drop,
    output phase, phase_start, obj_total, done, timeout, err_underflow, err_overflow
  );
endinterface

// File: rtl/svt_phase_sequencer.sv
// svt_phase_sequencer: steps requesters through build/connect/run/drain and waits on their objections
module svt_phase_sequencer #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int TIMEOUT_W = 16
) (
  input logic clk,
  input logic rst,
  svt_phase_sequencer_if.slave sq
);
  typedef enum logic [2:0] {IDLE, BUILD, CONNECT, RUN, DRAIN, DONE} phase_e;
  localparam int TW = CNT_W + 4;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  phase_e phase_q, phase_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [TW-1:0] total_q, total_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [TIMEOUT_W-1:0] run_q, run_d;
  logic phase_start_q, phase_start_d, done_q, done_d;
  logic tmo_q, tmo_d, unf_q, unf_d, ovf_q, ovf_d;
  logic ack_all, limit_hit, start_ok, counting;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= IDLE;
      ack_q <= '0;
      cnt_q <= '{default: '0};
      total_q <= '0;
      drain_q <= '0;
      run_q <= '0;
      phase_start_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q <= 1'b0;
      unf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ack_q <= ack_d;
      cnt_q <= cnt_d;
      total_q <= total_d;
      drain_q <= drain_d;
      run_q <= run_d;
      phase_start_q <= phase_start_d;
      done_q <= done_d;
      tmo_q <= tmo_d;
      unf_q <= unf_d;
      ovf_q <= ovf_d;
    end
  end
  // Timeout outranks every other exit from RUN/DRAIN
  always_comb begin
    phase_d = phase_q;
    ack_all = &(ack_q | sq.phase_ack);
    limit_hit = (sq.run_limit != '0) && (run_q == sq.run_limit - TIMEOUT_W'(1));
    case (phase_q)
      IDLE, DONE: if (sq.start) phase_d = BUILD;
      BUILD: if (ack_all) phase_d = CONNECT;
      CONNECT: if (ack_all) phase_d = RUN;
      RUN: begin
        if (limit_hit) phase_d = DONE;
        else if (total_q == '0 && sq.raise == '0) phase_d = DRAIN;
      end
      DRAIN: begin
        if (limit_hit) phase_d = DONE;
        else if (|sq.raise) phase_d = RUN;
        else if (drain_q == DW'(DRAIN_CYCLES - 1)) phase_d = DONE;
      end
      default: phase_d = IDLE;
    endcase
  end
  always_comb begin
    start_ok = sq.start && (phase_q == IDLE || phase_q == DONE);
    counting = phase_q inside {BUILD, CONNECT, RUN, DRAIN};
    ovf_d = ovf_q & ~start_ok;
    unf_d = unf_q & ~start_ok;
    total_d = '0;
    for (int r = 0; r < N_REQ; r++) begin
      cnt_d[r] = start_ok ? '0 : cnt_q[r];
      if (counting && sq.raise[r] && !sq.drop[r]) begin
        if (&cnt_q[r]) ovf_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (counting && sq.drop[r] && !sq.raise[r]) begin
        if (cnt_q[r] == '0) unf_d = 1'b1;
        else cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      total_d = total_d + TW'(cnt_d[r]);
    end
    ack_d = (phase_d != phase_q || !(phase_q inside {BUILD, CONNECT})) ? '0 : ack_q | sq.phase_ack;
    drain_d = (phase_q == DRAIN && phase_d == DRAIN) ? drain_q + DW'(1) : '0;
    run_d = (phase_q inside {RUN, DRAIN}) ? run_q + TIMEOUT_W'(1) : '0;
    tmo_d = start_ok ? 1'b0 : tmo_q | ((phase_q inside {RUN, DRAIN}) && limit_hit);
    phase_start_d = phase_d != phase_q && (phase_d inside {BUILD, CONNECT, RUN}) && phase_q != DRAIN;
    done_d = phase_d == DONE;
  end
  assign sq.phase = phase_q;
  assign sq.phase_start = phase_start_q;
  assign sq.obj_total = total_q;
  assign sq.done = done_q;
  assign sq.timeout = tmo_q;
  assign sq.err_underflow = unf_q;
  assign sq.err_overflow = ovf_q;
endmodule
